// File: rtl/usb_sched_pkg.sv
// rtl/usb_sched_pkg.sv - shared encodings for the USB transaction scheduler
package usb_sched_pkg;

    typedef enum logic [1:0] {
        TT_SETUP    = 2'd0,
        TT_IN       = 2'd1,
        TT_OUTDATA0 = 2'd2,
        TT_OUTDATA1 = 2'd3
    } transType_t;

    typedef enum logic [2:0] {
        RX_TIMEOUT      = 3'd0,
        RX_CRC_ERR      = 3'd1,
        RX_BITSTUFF_ERR = 3'd2,
        RX_OVERFLOW     = 3'd3,
        RX_NAK          = 3'd4,
        RX_STALL        = 3'd5,
        RX_ACK          = 3'd6,
        RX_DATA_SEQ     = 3'd7
    } rxBit_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD,
        S_REQ,
        S_WAIT,
        S_EVAL,
        S_SOFWAIT,
        S_BACKOFF,
        S_REPORT
    } schedState_t;

    typedef struct packed {
        transType_t  dType;
        logic        iso;
        logic [6:0]  addr;
        logic [3:0]  endP;
    } desc_t;

endpackage

// File: rtl/usb_desc_fifo.sv
// rtl/usb_desc_fifo.sv - descriptor FIFO with single-cycle flush, level and full
module usb_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     rdEn,
    output logic [WIDTH-1:0]         rdData,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doWr;
    logic             doRd;

    // flush outranks a push in the same cycle
    assign doWr   = wrEn && !full && !flush;
    assign doRd   = rdEn && !empty;
    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign level  = count;
    assign rdData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doWr) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) rdPtr <= rdPtr + 1'b1;
            count <= count + {{AW{1'b0}}, doWr} - {{AW{1'b0}}, doRd};
        end
    end

endmodule

// File: rtl/usb_trans_scheduler.sv
// rtl/usb_trans_scheduler.sv - sequences queued descriptors into the host controller with retry
module usb_trans_scheduler
    import usb_sched_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter int          MAX_RETRY   = 3,
    parameter logic [15:0] FS_GUARD    = 16'd46000,
    parameter logic [15:0] LS_GUARD    = 16'd40000,
    parameter logic [7:0]  ERR_BACKOFF = 8'd32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     descWEn,
    input  logic [1:0]               descType,
    input  logic                     descIso,
    input  logic [6:0]               descAddr,
    input  logic [3:0]               descEndP,
    output logic                     descFull,
    output logic [$clog2(DEPTH):0]   descLevel,
    input  logic                     flush,
    output logic                     transReq,
    output logic [1:0]               transType,
    output logic [6:0]               TxAddr,
    output logic [3:0]               TxEndP,
    output logic                     isoEn,
    input  logic                     transDone,
    input  logic [7:0]               RxPktStatus,
    input  logic [15:0]              SOFTimer,
    input  logic                     SOFSent,
    input  logic                     fullSpeedRate,
    output logic                     resultValid,
    output logic [7:0]               resultStatus,
    output logic [3:0]               resultRetries,
    output logic                     busy
);
    schedState_t state, stateNext;
    desc_t       pushDesc, fifoDesc, cur;
    logic        fifoEmpty;
    logic        pop;
    logic [3:0]  retryCnt;
    logic [7:0]  statusReg;
    logic [7:0]  backoffCnt;
    logic [15:0] guardLimit;
    logic        canRetry;
    logic        finalStatus;
    logic        linkErr;

    assign pushDesc = '{dType: transType_t'(descType), iso: descIso, addr: descAddr, endP: descEndP};

    usb_desc_fifo #(.DEPTH(DEPTH), .WIDTH($bits(desc_t))) uFifo (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (descWEn),
        .wrData (pushDesc),
        .rdEn   (pop),
        .rdData (fifoDesc),
        .flush  (flush),
        .full   (descFull),
        .empty  (fifoEmpty),
        .level  (descLevel)
    );

    assign transType     = cur.dType;
    assign TxAddr        = cur.addr;
    assign TxEndP        = cur.endP;
    assign isoEn         = cur.iso;
    assign resultStatus  = statusReg;
    assign resultRetries = retryCnt;

    assign guardLimit  = fullSpeedRate ? FS_GUARD : LS_GUARD;
    assign canRetry    = (retryCnt < 4'(MAX_RETRY));
    assign finalStatus = statusReg[RX_ACK] | statusReg[RX_STALL] | statusReg[RX_OVERFLOW] | cur.iso;
    assign linkErr     = statusReg[RX_TIMEOUT] | statusReg[RX_CRC_ERR] | statusReg[RX_BITSTUFF_ERR];

    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifoEmpty && !flush) begin
                    pop       = 1'b1;
                    stateNext = S_GUARD;
                end
            end
            // an SOF pulse opens a fresh frame even if the timer has not been read back yet
            S_GUARD:   if (SOFTimer < guardLimit || SOFSent) stateNext = S_REQ;
            S_REQ:     stateNext = S_WAIT;
            S_WAIT:    if (transDone) stateNext = S_EVAL;
            S_EVAL: begin
                if (finalStatus)                             stateNext = S_REPORT;
                else if (statusReg[RX_NAK] && canRetry)      stateNext = S_SOFWAIT;
                else if (linkErr && canRetry)                stateNext = S_BACKOFF;
                else                                         stateNext = S_REPORT;
            end
            S_SOFWAIT: if (SOFSent) stateNext = S_GUARD;
            S_BACKOFF: if (backoffCnt == 8'd0) stateNext = S_GUARD;
            S_REPORT:  stateNext = S_IDLE;
            default:   stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cur         <= '0;
            retryCnt    <= '0;
            statusReg   <= '0;
            backoffCnt  <= '0;
            transReq    <= 1'b0;
            resultValid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= stateNext;
            transReq    <= (stateNext == S_WAIT);
            resultValid <= (stateNext == S_REPORT);
            busy        <= (stateNext != S_IDLE);
            if (pop) begin
                cur      <= fifoDesc;
                retryCnt <= '0;
            end
            if (state == S_WAIT && transDone) statusReg <= RxPktStatus;
            if (state == S_EVAL && (stateNext == S_SOFWAIT || stateNext == S_BACKOFF))
                retryCnt <= retryCnt + 4'd1;
            // loaded one short so BACKOFF lasts exactly ERR_BACKOFF cycles
            if (state == S_EVAL)         backoffCnt <= ERR_BACKOFF - 8'd1;
            else if (state == S_BACKOFF) backoffCnt <= backoffCnt - 8'd1;
        end
    end

endmodule
